// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared types and constants for the PS/2 receiver
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_t;

  localparam logic [7:0] PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PREFIX_BRK = 8'hF0;

  typedef struct packed {
    logic       brk;
    logic       ext;
    logic [7:0] code;
  } ps2_event_t;

endpackage

// File: rtl/ps2_event_fifo.sv
// rtl/ps2_event_fifo.sv - first-word-fall-through event FIFO with overflow pulse
module ps2_event_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_empty,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             r_overflow;
  logic             w_empty;
  logic             w_full;
  logic             w_do_pop;
  logic             w_do_push;

  // Full/empty come from the occupancy count; a pop frees a slot for a same-cycle push
  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CW'(DEPTH));
  assign w_do_pop  = i_pop & ~w_empty;
  assign w_do_push = i_push & (~w_full | w_do_pop);

  // Storage array, no reset needed since reads are masked while empty
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointers wrap naturally (power-of-two depth); count tracks net push/pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= i_push & w_full & ~w_do_pop;
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_data     = w_empty ? '0 : r_mem[r_rd_ptr];
  assign o_empty    = w_empty;
  assign o_full     = w_full;
  assign o_count    = r_count;
  assign o_overflow = r_overflow;

endmodule

// File: rtl/ps2_rx_fifo.sv
// rtl/ps2_rx_fifo.sv - PS/2 keyboard frame receiver with prefix folding into an event FIFO
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int CLK_HZ        = 50_000_000,
  parameter int TIMEOUT_US    = 2000,
  parameter int FIFO_DEPTH    = 8,
  parameter int DECODE_PREFIX = 1
) (
  input  logic                          clk_50MHz,
  input  logic                          rst_n,
  input  logic                          ps2_clk,
  input  logic                          ps2_data,
  input  logic                          rd_en,
  output logic [9:0]                    rd_data,
  output logic                          empty,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          parity_err,
  output logic                          frame_err,
  output logic                          overflow
);

  localparam int TO_CYC = CLK_HZ / 1_000_000 * TIMEOUT_US;
  localparam int TW     = $clog2(TO_CYC + 1);

  logic        r_clk_s1, r_clk_s2, r_clk_prev;
  logic        r_dat_s1, r_dat_s2;
  logic        w_fall;

  ps2_state_t  r_state;
  logic [2:0]  r_bit_idx;
  logic [7:0]  r_shift;
  logic        r_par_ok;
  logic [TW-1:0] r_timer;
  logic        r_brk, r_ext;
  logic        r_push;
  ps2_event_t  r_push_data;
  logic        r_parity_err, r_frame_err;

  // Two-flop synchronisers plus a delayed copy of the clock for edge detection
  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_clk_s1   <= 1'b1;
      r_clk_s2   <= 1'b1;
      r_clk_prev <= 1'b1;
      r_dat_s1   <= 1'b1;
      r_dat_s2   <= 1'b1;
    end else begin
      r_clk_s1   <= ps2_clk;
      r_clk_s2   <= r_clk_s1;
      r_clk_prev <= r_clk_s2;
      r_dat_s1   <= ps2_data;
      r_dat_s2   <= r_dat_s1;
    end
  end

  assign w_fall = r_clk_prev & ~r_clk_s2;

  // Frame FSM: one step per PS/2 falling edge, watchdog aborts stalled frames
  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_bit_idx    <= '0;
      r_shift      <= '0;
      r_par_ok     <= 1'b0;
      r_timer      <= '0;
      r_brk        <= 1'b0;
      r_ext        <= 1'b0;
      r_push       <= 1'b0;
      r_push_data  <= '0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_push       <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;

      if (w_fall || r_state == ST_IDLE) r_timer <= '0;
      else                              r_timer <= r_timer + 1'b1;

      if (r_state != ST_IDLE && !w_fall && r_timer >= TW'(TO_CYC)) begin
        r_frame_err <= 1'b1;
        r_brk       <= 1'b0;
        r_ext       <= 1'b0;
        r_state     <= ST_IDLE;
        r_bit_idx   <= '0;
        r_timer     <= '0;
      end else if (w_fall) begin
        case (r_state)
          ST_IDLE: begin
            if (!r_dat_s2) begin
              r_state   <= ST_DATA;
              r_bit_idx <= '0;
            end
          end
          ST_DATA: begin
            r_shift   <= {r_dat_s2, r_shift[7:1]};
            r_bit_idx <= r_bit_idx + 3'd1;
            if (r_bit_idx == 3'd7) r_state <= ST_PARITY;
          end
          ST_PARITY: begin
            r_par_ok <= (^r_shift) ^ r_dat_s2;
            r_state  <= ST_STOP;
          end
          ST_STOP: begin
            r_state   <= ST_IDLE;
            r_bit_idx <= '0;
            if (!r_dat_s2) begin
              r_frame_err <= 1'b1;
              r_brk       <= 1'b0;
              r_ext       <= 1'b0;
            end else if (!r_par_ok) begin
              r_parity_err <= 1'b1;
              r_brk        <= 1'b0;
              r_ext        <= 1'b0;
            end else if (DECODE_PREFIX != 0) begin
              if (r_shift == PREFIX_EXT) begin
                r_ext <= 1'b1;
              end else if (r_shift == PREFIX_BRK) begin
                r_brk <= 1'b1;
              end else begin
                r_push      <= 1'b1;
                r_push_data <= '{brk: r_brk, ext: r_ext, code: r_shift};
                r_brk       <= 1'b0;
                r_ext       <= 1'b0;
              end
            end else begin
              r_push      <= 1'b1;
              r_push_data <= '{brk: 1'b0, ext: 1'b0, code: r_shift};
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  ps2_event_fifo #(
    .WIDTH ($bits(ps2_event_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk_50MHz),
    .rst_n      (rst_n),
    .i_push     (r_push),
    .i_data     (r_push_data),
    .i_pop      (rd_en),
    .o_data     (rd_data),
    .o_empty    (empty),
    .o_full     (full),
    .o_count    (count),
    .o_overflow (overflow)
  );

  assign parity_err = r_parity_err;
  assign frame_err  = r_frame_err;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb/tb_ps2_rx_fifo.sv - self-checking bench for ps2_rx_fifo (prefix-decoding and raw instances)
module tb_ps2_rx_fifo;

  localparam int HALF = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;
  logic rd_en_a = 1'b0;
  logic rd_en_b = 1'b0;

  logic [9:0] rd_data_a, rd_data_b;
  logic       empty_a, full_a, perr_a, ferr_a, ovf_a;
  logic       empty_b, full_b, perr_b, ferr_b, ovf_b;
  logic [2:0] count_a;
  logic [3:0] count_b;

  always #5 clk = ~clk;

  ps2_rx_fifo #(.CLK_HZ(1_000_000), .TIMEOUT_US(200), .FIFO_DEPTH(4), .DECODE_PREFIX(1)) dut_a (
    .clk_50MHz(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .rd_en(rd_en_a),
    .rd_data(rd_data_a), .empty(empty_a), .full(full_a), .count(count_a),
    .parity_err(perr_a), .frame_err(ferr_a), .overflow(ovf_a));

  ps2_rx_fifo #(.CLK_HZ(1_000_000), .TIMEOUT_US(200), .FIFO_DEPTH(8), .DECODE_PREFIX(0)) dut_b (
    .clk_50MHz(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .rd_en(rd_en_b),
    .rd_data(rd_data_b), .empty(empty_b), .full(full_b), .count(count_b),
    .parity_err(perr_b), .frame_err(ferr_b), .overflow(ovf_b));

  int n_checks = 0;
  int n_err = 0;

  int n_perr_a = 0, n_ferr_a = 0, n_ovf_a = 0;
  int n_perr_b = 0, n_ferr_b = 0, n_ovf_b = 0;

  always @(negedge clk) begin
    if (perr_a) n_perr_a++;
    if (ferr_a) n_ferr_a++;
    if (ovf_a)  n_ovf_a++;
    if (perr_b) n_perr_b++;
    if (ferr_b) n_ferr_b++;
    if (ovf_b)  n_ovf_b++;
  end

  logic [9:0] q_a[$];
  logic [9:0] q_b[$];
  bit m_brk = 0, m_ext = 0;
  int m_perr = 0, m_ferr = 0, m_ovf_a = 0, m_ovf_b = 0;

  logic last_e_before, last_e_after;

  typedef struct {
    logic [7:0] code;
    bit         bad_par;
    bit         stop;
    bit         exp_push;
    logic [9:0] exp_val;
    int         exp_perr;
    int         exp_ferr;
  } vec_t;

  vec_t vecs[12];

  initial begin
    #600000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: one keyboard frame's effect on both FIFOs, from the decoding rules
  task automatic model_frame(input logic [7:0] code, input bit bad_par, input bit stop);
    if (!stop) begin
      m_ferr++; m_brk = 0; m_ext = 0;
    end else if (bad_par) begin
      m_perr++; m_brk = 0; m_ext = 0;
    end else begin
      if (code == 8'hE0) m_ext = 1;
      else if (code == 8'hF0) m_brk = 1;
      else begin
        if (q_a.size() >= 4) m_ovf_a++;
        else q_a.push_back({m_brk, m_ext, code});
        m_brk = 0; m_ext = 0;
      end
      if (q_b.size() >= 8) m_ovf_b++;
      else q_b.push_back({2'b00, code});
    end
  endtask

  task automatic send_frame(input logic [7:0] code, input bit bad_par, input bit stop,
                            input int nbits, input bit pop_on_push);
    logic [10:0] b;
    b = {stop, (~^code) ^ bad_par, code, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      ps2_data = b[i];
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      if (i == 10) begin
        repeat (3) @(negedge clk);
        last_e_before = empty_a;
        if (pop_on_push) rd_en_a = 1'b1;
        @(negedge clk);
        last_e_after = empty_a;
        rd_en_a = 1'b0;
        repeat (HALF - 4) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
      ps2_clk = 1'b1;
    end
  endtask

  task automatic check_model(input string tag);
    logic [9:0] ha, hb;
    ha = (q_a.size() > 0) ? q_a[0] : 10'h0;
    hb = (q_b.size() > 0) ? q_b[0] : 10'h0;
    chk({tag, "_count_a"}, count_a, q_a.size());
    chk({tag, "_empty_a"}, empty_a, q_a.size() == 0);
    chk({tag, "_full_a"}, full_a, q_a.size() == 4);
    chk({tag, "_head_a"}, rd_data_a, ha);
    chk({tag, "_count_b"}, count_b, q_b.size());
    chk({tag, "_head_b"}, rd_data_b, hb);
    chk({tag, "_perr_a"}, n_perr_a, m_perr);
    chk({tag, "_ferr_a"}, n_ferr_a, m_ferr);
    chk({tag, "_perr_b"}, n_perr_b, m_perr);
    chk({tag, "_ferr_b"}, n_ferr_b, m_ferr);
    chk({tag, "_ovf_a"}, n_ovf_a, m_ovf_a);
    chk({tag, "_ovf_b"}, n_ovf_b, m_ovf_b);
  endtask

  task automatic pop_a();
    logic [9:0] exp;
    exp = (q_a.size() > 0) ? q_a[0] : 10'h0;
    chk("pop_head_a", rd_data_a, exp);
    rd_en_a = 1'b1;
    @(negedge clk);
    rd_en_a = 1'b0;
    if (q_a.size() > 0) void'(q_a.pop_front());
    @(negedge clk);
  endtask

  task automatic pop_b();
    logic [9:0] exp;
    exp = (q_b.size() > 0) ? q_b[0] : 10'h0;
    chk("pop_head_b", rd_data_b, exp);
    rd_en_b = 1'b1;
    @(negedge clk);
    rd_en_b = 1'b0;
    if (q_b.size() > 0) void'(q_b.pop_front());
    @(negedge clk);
  endtask

  task automatic drain();
    while (q_a.size() > 0) pop_a();
    while (q_b.size() > 0) pop_b();
    check_model("drain");
  endtask

  task automatic frame_and_check(input logic [7:0] code, input bit bad_par, input bit stop, input string tag);
    send_frame(code, bad_par, stop, 11, 1'b0);
    model_frame(code, bad_par, stop);
    repeat (4) @(negedge clk);
    check_model(tag);
  endtask

  initial begin
    vecs[0]  = '{8'h1C, 0, 1, 1, 10'h01C, 0, 0};
    vecs[1]  = '{8'hE0, 0, 1, 0, 10'h000, 0, 0};
    vecs[2]  = '{8'hF0, 0, 1, 0, 10'h000, 0, 0};
    vecs[3]  = '{8'h75, 0, 1, 1, 10'h375, 0, 0};
    vecs[4]  = '{8'h1C, 1, 1, 0, 10'h000, 1, 0};
    vecs[5]  = '{8'h1B, 0, 1, 1, 10'h01B, 0, 0};
    vecs[6]  = '{8'hE0, 0, 1, 0, 10'h000, 0, 0};
    vecs[7]  = '{8'h1C, 0, 0, 0, 10'h000, 0, 1};
    vecs[8]  = '{8'h29, 0, 1, 1, 10'h029, 0, 0};
    vecs[9]  = '{8'hF0, 0, 1, 0, 10'h000, 0, 0};
    vecs[10] = '{8'h1C, 1, 1, 0, 10'h000, 1, 0};
    vecs[11] = '{8'h16, 0, 1, 1, 10'h016, 0, 0};

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_empty", empty_a, 1);
    chk("reset_count", count_a, 0);
    chk("reset_rd_data", rd_data_a, 0);
    chk("reset_full", full_a, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // First frame latency: empty drops exactly two cycles after edge detection
    send_frame(8'h1C, 0, 1, 11, 1'b0);
    model_frame(8'h1C, 0, 1);
    chk("lat_empty_before", last_e_before, 1);
    chk("lat_empty_after", last_e_after, 0);
    repeat (4) @(negedge clk);
    check_model("first");
    drain();

    // Pop on empty is ignored
    pop_a();
    chk("empty_pop_count", count_a, 0);
    chk("empty_pop_empty", empty_a, 1);

    // Table-driven frames
    for (int i = 0; i < 12; i++) begin
      int p0, f0;
      p0 = n_perr_a;
      f0 = n_ferr_a;
      send_frame(vecs[i].code, vecs[i].bad_par, vecs[i].stop, 11, 1'b0);
      model_frame(vecs[i].code, vecs[i].bad_par, vecs[i].stop);
      repeat (4) @(negedge clk);
      chk($sformatf("vec%0d_count", i), count_a, vecs[i].exp_push);
      if (vecs[i].exp_push) chk($sformatf("vec%0d_data", i), rd_data_a, vecs[i].exp_val);
      chk($sformatf("vec%0d_perr", i), n_perr_a - p0, vecs[i].exp_perr);
      chk($sformatf("vec%0d_ferr", i), n_ferr_a - f0, vecs[i].exp_ferr);
      check_model($sformatf("vec%0d", i));
      drain();
    end

    // Timeout mid-frame after an E0: flags clear, next frame decodes plain
    frame_and_check(8'hE0, 0, 1, "to_prefix");
    send_frame(8'h5D, 0, 1, 5, 1'b0);
    repeat (300) @(negedge clk);
    m_ferr++; m_brk = 0; m_ext = 0;
    check_model("timeout");
    frame_and_check(8'h29, 0, 1, "after_to");
    chk("after_to_val", rd_data_a, 10'h029);
    drain();

    // Overflow: five bytes into a 4-deep FIFO
    for (int i = 1; i <= 5; i++) frame_and_check(8'(i * 8'h11), 0, 1, $sformatf("ovf%0d", i));
    chk("ovf_full", full_a, 1);
    chk("ovf_count", count_a, 4);
    chk("ovf_pulses", n_ovf_a, 1);
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("ovf_pop%0d", i), rd_data_a, 10'(i * 8'h11));
      pop_a();
    end
    chk("ovf_empty", empty_a, 1);
    drain();

    // Push and pop in the same cycle while full
    for (int i = 0; i < 4; i++) frame_and_check(8'h30 + 8'(i), 0, 1, "refill");
    chk("pp_head_before", rd_data_a, q_a[0]);
    send_frame(8'h66, 0, 1, 11, 1'b1);
    void'(q_a.pop_front());
    model_frame(8'h66, 0, 1);
    repeat (4) @(negedge clk);
    chk("pp_count", count_a, 4);
    chk("pp_head_after", rd_data_a, 10'h031);
    check_model("pushpop");
    drain();

    // Reset during data bit 5 with a stored entry
    frame_and_check(8'h3C, 0, 1, "pre_rst");
    send_frame(8'h5A, 0, 1, 7, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("rst_empty", empty_a, 1);
    chk("rst_count", count_a, 0);
    chk("rst_full", full_a, 0);
    chk("rst_rd_data", rd_data_a, 0);
    chk("rst_perr", perr_a, 0);
    chk("rst_ferr", ferr_a, 0);
    chk("rst_ovf", ovf_a, 0);
    chk("rst_count_b", count_b, 0);
    q_a.delete(); q_b.delete(); m_brk = 0; m_ext = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    frame_and_check(8'h5A, 0, 1, "post_rst");
    chk("post_rst_val", rd_data_a, 10'h05A);
    drain();

    // Randomised frames and pops against the reference model
    for (int it = 0; it < 25; it++) begin
      int r;
      logic [7:0] code;
      bit bp, st;
      r = $urandom_range(0, 9);
      code = (r < 2) ? 8'hE0 : (r < 4) ? 8'hF0 : 8'($urandom_range(0, 255));
      bp = ($urandom_range(0, 7) == 0);
      st = ($urandom_range(0, 7) != 0);
      frame_and_check(code, bp, st, $sformatf("rnd%0d", it));
      for (int k = $urandom_range(0, 2); k > 0; k--) pop_a();
      if ($urandom_range(0, 1) == 1) pop_b();
      check_model($sformatf("rnd%0d_pop", it));
    end
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/ps2_rx_fifo.md
PS2_RX_FIFO -- requirements
Module: ps2_rx_fifo

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter TIMEOUT_US, default 2000, maximum gap between PS/2 falling edges inside a frame.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, event FIFO entries; power of two, minimum 2.
REQ-004 SHALL have parameter DECODE_PREFIX, default 1; 1 folds E0/F0 prefixes into flags, 0 pushes every raw byte.
REQ-005 SHALL have port clk_50MHz  in  1  system clock, the only clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-007 SHALL have port ps2_clk  in  1  raw PS/2 clock from the keyboard, asynchronous.
REQ-008 SHALL have port ps2_data  in  1  raw PS/2 data from the keyboard, asynchronous.
REQ-009 SHALL have port rd_en  in  1  pop request for the FIFO head.
REQ-010 SHALL have port rd_data  out  10  FIFO head {brk, ext, code[7:0]}, first-word-fall-through.
REQ-011 SHALL have port empty  out  1  FIFO holds no entries.
REQ-012 SHALL have port full  out  1  FIFO holds FIFO_DEPTH entries.
REQ-013 SHALL have port count  out  $clog2(FIFO_DEPTH)+1  current occupancy.
REQ-014 SHALL have port parity_err  out  1  one-cycle pulse on a parity failure.
REQ-015 SHALL have port frame_err  out  1  one-cycle pulse on a bad stop bit or a timeout.
REQ-016 SHALL have port overflow  out  1  one-cycle pulse when an event is dropped.

Function
REQ-017 SHALL pass ps2_clk and ps2_data through 2-flop synchronisers; a falling edge is synchronised ps2_clk going 1->0 between consecutive cycles.
REQ-018 SHALL sample synchronised ps2_data only in the cycle a falling edge is detected.
REQ-019 SHALL implement FSM IDLE->DATA->PARITY->STOP->IDLE, one transition per falling edge.
REQ-020 IDLE: data 0 at an edge is a start bit -> DATA, bit index 0; data 1 at an edge is ignored, state stays IDLE.
REQ-021 DATA: SHALL shift data bits LSB first; after bit index 7 -> PARITY.
REQ-022 PARITY: SHALL require odd parity (XOR of 8 data bits and the parity bit = 1); a failure is latched and checked at the stop bit.
REQ-023 STOP: data 1 with parity good = valid byte; data 1 with parity bad = parity_err pulse, byte discarded; data 0 = frame_err pulse, byte discarded; all cases -> IDLE.
REQ-024 SHALL count cycles since the last falling edge; if that count reaches CLK_HZ/1_000_000*TIMEOUT_US in any state other than IDLE: frame_err pulse, -> IDLE, partial byte discarded.
REQ-025 DECODE_PREFIX=1: valid E0 sets ext, valid F0 sets brk, neither pushes; any other byte pushes {brk, ext, byte}, then both flags clear.
REQ-026 DECODE_PREFIX=0: every valid byte SHALL push {0, 0, byte}.
REQ-027 Any parity_err or frame_err SHALL clear the brk and ext flags.
REQ-028 A push SHALL occur in the cycle after the stop-bit edge is detected; empty, count and rd_data SHALL update one cycle later.
REQ-029 rd_en with empty=0 SHALL pop the head; rd_en with empty=1 is ignored and leaves state unchanged.
REQ-030 Push while full with no pop: entry dropped, overflow pulses, contents unchanged.
REQ-031 Push and pop in the same cycle SHALL both take effect, count unchanged, no overflow, including when full.
REQ-032 Pointers SHALL wrap modulo FIFO_DEPTH; full and empty SHALL derive from count.
REQ-033 rd_data SHALL be 0 while empty.

Reset
REQ-034 rst_n low SHALL immediately force: FSM IDLE, bit index 0, timeout counter 0, flags 0, pointers 0, count 0, empty 1, full 0, rd_data 0, all pulses 0, synchroniser flops 1.
REQ-035 Reset mid-frame SHALL discard the partial byte; after release, decoding resumes at the next start bit.

Structure
REQ-036 Package ps2_pkg SHALL hold the FSM state enum, the E0/F0 prefix constants and the 10-bit event struct.
REQ-037 The FIFO SHALL be sub-module ps2_event_fifo, parameterised by width and depth; framing/decoding stays in ps2_rx_fifo.

Verification
REQ-038 Frame 0x1C with odd parity 0 and stop 1 -> one entry 0x01C; empty falls 2 cycles after the stop edge.
REQ-039 Bytes E0, F0, 75 -> single entry 0x375 (brk=1, ext=1); DECODE_PREFIX=0 -> three entries 0x0E0, 0x0F0, 0x075.
REQ-040 0x1C with parity bit 1 -> parity_err pulse, no push; then 0x1B -> entry 0x01B with flags 0.
REQ-041 Clock stops after 4 data bits for 2.5 ms -> frame_err pulse, FSM IDLE; next full frame 0x29 -> entry 0x029.
REQ-042 FIFO_DEPTH=4, push 5 bytes with no reads -> full=1, count=4, one overflow pulse; 4 pops in order return the first 4 bytes, then empty=1.
REQ-043 rst_n low during data bit 5 -> all outputs at reset values at once; frame after release decodes correctly.
